// File: rtl/message_rx_channel.sv
// Receive-side deserializer for the 2-bit message control channel.
// Bits arrive LSB first, one per bit_valid strobe, while rx_active frames them.
// A completed MSG_LEN-bit message is presented through a valid/ready holding
// register. Aborted frames, surplus bits and dropped messages are reported as
// single-cycle registered pulses.
module message_rx_channel #(
  parameter int MSG_LEN = 120,
  parameter int ADDR_W  = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_active,
  input  logic               bit_valid,
  input  logic [1:0]         rx_data,
  input  logic               msg_ready,
  output logic [MSG_LEN-1:0] msg_data,
  output logic               msg_err,
  output logic               msg_valid,
  output logic [ADDR_W-1:0]  bit_count,
  output logic               frame_abort,
  output logic               overrun,
  output logic               msg_dropped
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] TAIL = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

  logic [1:0]         state;
  logic [MSG_LEN-1:0] shift_reg;
  logic [MSG_LEN-1:0] final_msg;
  logic               err_flag;
  logic               bit_strobe;
  logic               complete;
  logic               can_load;

  // A bit is captured only inside a live frame; the last index completes it.
  assign bit_strobe = (state == RECV) && rx_active && bit_valid;
  assign complete   = bit_strobe && (bit_count == LAST_IDX);
  // The holding register accepts a new message if empty or draining this cycle.
  assign can_load   = !msg_valid || msg_ready;

  // Completed message image: stored bits plus the final bit arriving this cycle.
  always_comb begin
    // NOTE: combinational outputs get a full default first so no latch is inferred.
    final_msg              = shift_reg;
    final_msg[MSG_LEN-1]   = rx_data[0];
  end

  // Frame state machine, bit counter and per-frame reserved-lane error flag.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_count <= '0;
      err_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_count <= '0;
          err_flag  <= 1'b0;
          if (rx_active) state <= RECV;
        end
        RECV: begin
          if (!rx_active) begin
            state     <= IDLE;
            bit_count <= '0;
            err_flag  <= 1'b0;
          end else if (bit_valid) begin
            err_flag  <= err_flag | rx_data[1];
            // Counter ends at MSG_LEN on completion and holds there in TAIL.
            bit_count <= bit_count + 1'b1;
            if (bit_count == LAST_IDX) state <= TAIL;
          end
        end
        TAIL: begin
          if (!rx_active) begin
            state     <= IDLE;
            bit_count <= '0;
            err_flag  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          bit_count <= '0;
          err_flag  <= 1'b0;
        end
      endcase
    end
  end

  // Shift register: each strobed bit lands at its own index, LSB first.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the shift register is a plain register bank, not a RAM, so it takes
    // the async reset like every other flop and shows all zeros after reset.
    if (!rst) begin
      shift_reg <= '0;
    end else if (bit_strobe) begin
      shift_reg[bit_count] <= rx_data[0];
    end
  end

  // Holding register with valid/ready handshake; a reload wins over a drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_data  <= '0;
      msg_err   <= 1'b0;
      msg_valid <= 1'b0;
    end else if (complete && can_load) begin
      msg_data  <= final_msg;
      msg_err   <= err_flag | rx_data[1];
      msg_valid <= 1'b1;
    end else if (msg_valid && msg_ready) begin
      msg_valid <= 1'b0;
    end
  end

  // Single-cycle event pulses, registered from the current-cycle conditions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_abort <= 1'b0;
      overrun     <= 1'b0;
      msg_dropped <= 1'b0;
    end else begin
      frame_abort <= (state == RECV) && !rx_active;
      overrun     <= (state == TAIL) && rx_active && bit_valid;
      msg_dropped <= complete && !can_load;
    end
  end

endmodule

// File: tb/tb_message_rx_channel.sv
// Directed testbench for message_rx_channel (MSG_LEN=120, ADDR_W=7).
// Inputs change 1 ns after the rising edge; outputs are read at that same
// point, so each read reflects the edge just taken.
module tb_message_rx_channel;

  localparam logic [119:0] PAT_A = {15{8'hA5}};
  localparam logic [119:0] PAT_B = {15{8'h3C}};
  localparam logic [119:0] PAT_C = 120'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_active;
  logic         bit_valid;
  logic [1:0]   rx_data;
  logic         msg_ready;
  logic [119:0] msg_data;
  logic         msg_err;
  logic         msg_valid;
  logic [6:0]   bit_count;
  logic         frame_abort;
  logic         overrun;
  logic         msg_dropped;

  int tests_run    = 0;
  int tests_failed = 0;
  int abort_cnt    = 0;
  int overrun_cnt  = 0;
  int drop_cnt     = 0;

  message_rx_channel #(.MSG_LEN(120), .ADDR_W(7)) dut (
    .clk(clk), .rst(rst), .rx_active(rx_active), .bit_valid(bit_valid),
    .rx_data(rx_data), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_err(msg_err), .msg_valid(msg_valid), .bit_count(bit_count),
    .frame_abort(frame_abort), .overrun(overrun), .msg_dropped(msg_dropped)
  );

  always #5 clk = ~clk;

  // Count high cycles of each pulse output, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_abort) abort_cnt   <= abort_cnt + 1;
    if (overrun)     overrun_cnt <= overrun_cnt + 1;
    if (msg_dropped) drop_cnt    <= drop_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise rx_active with a junk strobe that must be ignored in IDLE.
  task automatic start_frame();
    rx_active = 1'b1;
    bit_valid = 1'b1;
    rx_data   = 2'b11;
    step();
    bit_valid = 1'b0;
    rx_data   = 2'b00;
  endtask

  task automatic end_frame();
    rx_active = 1'b0;
    bit_valid = 1'b0;
    rx_data   = 2'b00;
    step();
  endtask

  // Strobe bits [from, to) of d; err_bit marks the bit with reserved lane set.
  task automatic send_bits(input logic [119:0] d, input int from, input int to,
                           input int err_bit);
    for (int k = from; k < to; k++) begin
      rx_active = 1'b1;
      bit_valid = 1'b1;
      rx_data   = {(k == err_bit), d[k % 120]};
      step();
    end
    bit_valid = 1'b0;
    rx_data   = 2'b00;
  endtask

  task automatic consume();
    msg_ready = 1'b1;
    step();
    msg_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_active = 1'b0; bit_valid = 1'b0; rx_data = 2'b00; msg_ready = 1'b0;
    #3;
    tests_run++;
    if ({msg_valid, msg_err, frame_abort, overrun, msg_dropped} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 00000",
               {msg_valid, msg_err, frame_abort, overrun, msg_dropped});
    end
    tests_run++;
    if (msg_data !== 120'd0) begin
      tests_failed++; $display("FAIL reset_data: got %h expected 0", msg_data);
    end
    tests_run++;
    if (bit_count !== 7'd0) begin
      tests_failed++; $display("FAIL reset_count: got %0d expected 0", bit_count);
    end
    #4 rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int a0, o0, d0;
    a0 = abort_cnt; o0 = overrun_cnt; d0 = drop_cnt;
    start_frame();
    tests_run++;
    if (bit_count !== 7'd0) begin
      tests_failed++; $display("FAIL basic_ignore_first: got %0d expected 0", bit_count);
    end
    send_bits(PAT_A, 0, 119, -1);
    tests_run++;
    if (msg_valid !== 1'b0 || bit_count !== 7'd119) begin
      tests_failed++;
      $display("FAIL basic_pre_final: got valid=%b count=%0d expected valid=0 count=119",
               msg_valid, bit_count);
    end
    send_bits(PAT_A, 119, 120, -1);
    tests_run++;
    if (msg_valid !== 1'b1 || bit_count !== 7'd120) begin
      tests_failed++;
      $display("FAIL basic_complete: got valid=%b count=%0d expected valid=1 count=120",
               msg_valid, bit_count);
    end
    tests_run++;
    if (msg_data !== PAT_A || msg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_data: got %h err=%b expected %h err=0", msg_data, msg_err, PAT_A);
    end
    end_frame();
    step();
    tests_run++;
    if (abort_cnt != a0 || overrun_cnt != o0 || drop_cnt != d0) begin
      tests_failed++;
      $display("FAIL basic_no_pulses: got abort=%0d over=%0d drop=%0d expected 0 0 0",
               abort_cnt - a0, overrun_cnt - o0, drop_cnt - d0);
    end
    consume();
    tests_run++;
    if (msg_valid !== 1'b0) begin
      tests_failed++; $display("FAIL basic_consume: got valid=%b expected 0", msg_valid);
    end
  endtask

  task automatic test_err();
    start_frame();
    send_bits(PAT_B, 0, 120, 37);
    tests_run++;
    if (msg_valid !== 1'b1 || msg_err !== 1'b1 || msg_data !== PAT_B) begin
      tests_failed++;
      $display("FAIL err_lane: got valid=%b err=%b data=%h expected 1 1 %h",
               msg_valid, msg_err, msg_data, PAT_B);
    end
    end_frame();
  endtask

  // Runs with the errored PAT_B message still held unconsumed.
  task automatic test_abort();
    int a0;
    a0 = abort_cnt;
    start_frame();
    send_bits(PAT_C, 0, 50, -1);
    tests_run++;
    if (bit_count !== 7'd50) begin
      tests_failed++; $display("FAIL abort_count50: got %0d expected 50", bit_count);
    end
    end_frame();
    tests_run++;
    if (frame_abort !== 1'b1 || bit_count !== 7'd0) begin
      tests_failed++;
      $display("FAIL abort_pulse: got abort=%b count=%0d expected abort=1 count=0",
               frame_abort, bit_count);
    end
    tests_run++;
    if (msg_valid !== 1'b1 || msg_data !== PAT_B) begin
      tests_failed++;
      $display("FAIL abort_hold: got valid=%b data=%h expected 1 %h", msg_valid, msg_data, PAT_B);
    end
    step();
    tests_run++;
    if (frame_abort !== 1'b0 || abort_cnt - a0 != 1) begin
      tests_failed++;
      $display("FAIL abort_width: got abort=%b cycles=%0d expected 0 1",
               frame_abort, abort_cnt - a0);
    end
    consume();
    start_frame();
    send_bits(PAT_C, 0, 120, -1);
    tests_run++;
    if (msg_valid !== 1'b1 || msg_data !== PAT_C || msg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_next_frame: got valid=%b data=%h err=%b expected 1 %h 0",
               msg_valid, msg_data, msg_err, PAT_C);
    end
    end_frame();
    consume();
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = drop_cnt;
    start_frame();
    send_bits(PAT_A, 0, 120, -1);
    end_frame();
    start_frame();
    send_bits(PAT_B, 0, 120, -1);
    tests_run++;
    if (msg_dropped !== 1'b1 || msg_valid !== 1'b1 || msg_data !== PAT_A) begin
      tests_failed++;
      $display("FAIL drop_second: got drop=%b valid=%b data=%h expected 1 1 %h",
               msg_dropped, msg_valid, msg_data, PAT_A);
    end
    end_frame();
    tests_run++;
    if (msg_dropped !== 1'b0 || msg_data !== PAT_A) begin
      tests_failed++;
      $display("FAIL drop_width: got drop=%b data=%h expected 0 %h", msg_dropped, msg_data, PAT_A);
    end
    start_frame();
    send_bits(PAT_C, 0, 119, -1);
    msg_ready = 1'b1;
    send_bits(PAT_C, 119, 120, -1);
    msg_ready = 1'b0;
    tests_run++;
    if (msg_valid !== 1'b1 || msg_data !== PAT_C || msg_dropped !== 1'b0) begin
      tests_failed++;
      $display("FAIL reload_same_cycle: got valid=%b drop=%b data=%h expected 1 0 %h",
               msg_valid, msg_dropped, msg_data, PAT_C);
    end
    end_frame();
    tests_run++;
    if (drop_cnt - d0 != 1) begin
      tests_failed++; $display("FAIL drop_total: got %0d expected 1", drop_cnt - d0);
    end
    consume();
  endtask

  task automatic test_overrun();
    int o0, a0;
    o0 = overrun_cnt; a0 = abort_cnt;
    start_frame();
    send_bits(PAT_A, 0, 120, -1);
    tests_run++;
    if (msg_valid !== 1'b1 || msg_data !== PAT_A) begin
      tests_failed++;
      $display("FAIL overrun_complete: got valid=%b data=%h expected 1 %h", msg_valid, msg_data, PAT_A);
    end
    send_bits(~PAT_A, 120, 121, -1);
    tests_run++;
    if (overrun !== 1'b1 || bit_count !== 7'd120) begin
      tests_failed++;
      $display("FAIL overrun_first: got over=%b count=%0d expected 1 120", overrun, bit_count);
    end
    send_bits(~PAT_A, 121, 123, -1);
    step();
    step();
    tests_run++;
    if (overrun_cnt - o0 != 3 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_count: got cycles=%0d over=%b expected 3 0", overrun_cnt - o0, overrun);
    end
    tests_run++;
    if (msg_data !== PAT_A || msg_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_data: got %h valid=%b expected %h 1", msg_data, msg_valid, PAT_A);
    end
    end_frame();
    step();
    tests_run++;
    if (abort_cnt != a0) begin
      tests_failed++; $display("FAIL overrun_no_abort: got %0d expected 0", abort_cnt - a0);
    end
  endtask

  // Runs with the PAT_A message still held, so reset must clear it.
  task automatic test_async_reset();
    start_frame();
    send_bits(PAT_B, 0, 60, -1);
    tests_run++;
    if (bit_count !== 7'd60) begin
      tests_failed++; $display("FAIL rst_count60: got %0d expected 60", bit_count);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({msg_valid, msg_err, frame_abort, overrun, msg_dropped} !== 5'b0 ||
        msg_data !== 120'd0 || bit_count !== 7'd0) begin
      tests_failed++;
      $display("FAIL rst_async: got flags=%b data=%h count=%0d expected 00000 0 0",
               {msg_valid, msg_err, frame_abort, overrun, msg_dropped}, msg_data, bit_count);
    end
    rx_active = 1'b0; bit_valid = 1'b0; rx_data = 2'b00;
    #2 rst = 1'b1;
    step();
    step();
    tests_run++;
    if (frame_abort !== 1'b0 || msg_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_silent: got abort=%b valid=%b expected 0 0", frame_abort, msg_valid);
    end
    start_frame();
    send_bits(PAT_C, 0, 120, -1);
    tests_run++;
    if (msg_valid !== 1'b1 || msg_data !== PAT_C || msg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_next_frame: got valid=%b data=%h err=%b expected 1 %h 0",
               msg_valid, msg_data, msg_err, PAT_C);
    end
    end_frame();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err();
    test_abort();
    test_back_to_back();
    test_overrun();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
